tim_shadow_bank: RTL and testbench

Parametrised multi-channel preload/shadow register bank for the general-purpose timers. It holds a bus-writable buffer and an active shadow copy per channel: auto-reload, prescaler and compare values. Each channel can run in preload mode, where the shadow loads only on an update event, or in direct mode, where writes take effect immediately. Update-event gating (UDIS), request-source selection (URS), software update (UG) and an update interrupt flag are included. The block sits between the timer register interface and the counter/compare datapath.

---
 rtl/tim_shadow_bank.sv | 87 ++++++++
 tb/tb_tim_shadow_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tim_shadow_bank.sv
// Per-channel preload/shadow register bank for the general-purpose timers.
// Buffers take bus writes; shadows feed the counter/compare datapath.
module tim_shadow_bank #(
    parameter int                 WIDTH   = 16,
    parameter int                 NCH     = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 AW      = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [NCH-1:0]        pre_en,
    input  logic                  uev,
    input  logic                  ug,
    input  logic                  udis,
    input  logic                  urs,
    input  logic                  uif_clr,
    output logic [NCH*WIDTH-1:0]  buf_out,
    output logic [NCH*WIDTH-1:0]  sh_out,
    output logic [NCH-1:0]        pend,
    output logic                  uif,
    output logic                  upd_pulse
);

    localparam logic [31:0] NCH_U = 32'(NCH);

    logic [WIDTH-1:0] buf_r [NCH];
    logic [WIDTH-1:0] sh_r  [NCH];
    logic             uev_d;
    logic             uev_rise;
    logic             upd_uev;
    logic             upd;
    logic             wr_hit;

    assign uev_rise = uev & ~uev_d;
    assign upd_uev  = uev_rise & ~udis;
    assign upd      = upd_uev | ug;
    assign wr_hit   = wr_en && (32'(wr_addr) < NCH_U);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uev_d     <= 1'b0;
            upd_pulse <= 1'b0;
            uif       <= 1'b0;
            pend      <= '0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                buf_r[ch] <= RST_VAL;
                sh_r[ch]  <= RST_VAL;
            end
        end else begin
            uev_d     <= uev;
            upd_pulse <= upd;
            if (upd && (!urs || upd_uev))
                uif <= 1'b1;
            else if (uif_clr)
                uif <= 1'b0;
            // Write is evaluated after the transfer so a same-edge write wins
            // on pend/buf while the shadow takes the pre-write buffer value.
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (upd) begin
                    pend[ch] <= 1'b0;
                    if (pre_en[ch])
                        sh_r[ch] <= buf_r[ch];
                end
                if (wr_hit && (wr_addr == AW'(ch))) begin
                    buf_r[ch] <= wr_data;
                    if (pre_en[ch])
                        pend[ch] <= 1'b1;
                    else
                        sh_r[ch] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        buf_out = '0;
        sh_out  = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            buf_out[ch*WIDTH +: WIDTH] = buf_r[ch];
            sh_out[ch*WIDTH +: WIDTH]  = sh_r[ch];
        end
    end

endmodule

// File: tb/tb_tim_shadow_bank.sv
// Directed self-checking bench for tim_shadow_bank: a 4-channel instance for
// the main behaviour and a 3-channel instance for the out-of-range address.
module tb_tim_shadow_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  pre_en;
    logic [2:0]  pre_en3;
    logic        uev, ug, udis, urs, uif_clr;

    logic [63:0] buf_out, sh_out;
    logic [3:0]  pend;
    logic        uif, upd_pulse;

    logic [47:0] buf3_out, sh3_out;
    logic [2:0]  pend3;
    logic        uif3, upd_pulse3;

    int total = 0;
    int bad   = 0;

    tim_shadow_bank #(.WIDTH(16), .NCH(4), .RST_VAL(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pre_en(pre_en), .uev(uev), .ug(ug), .udis(udis), .urs(urs), .uif_clr(uif_clr),
        .buf_out(buf_out), .sh_out(sh_out), .pend(pend), .uif(uif), .upd_pulse(upd_pulse)
    );

    tim_shadow_bank #(.WIDTH(16), .NCH(3), .RST_VAL(16'h5A5A)) u_dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pre_en(pre_en3), .uev(uev), .ug(ug), .udis(udis), .urs(urs), .uif_clr(uif_clr),
        .buf_out(buf3_out), .sh_out(sh3_out), .pend(pend3), .uif(uif3), .upd_pulse(upd_pulse3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [15:0] f4(input logic [63:0] v, input int ch);
        return v[ch*16 +: 16];
    endfunction

    function automatic logic [15:0] f3(input logic [47:0] v, input int ch);
        return v[ch*16 +: 16];
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pre_en = '0; pre_en3 = '0;
        uev = 1'b0; ug = 1'b0; udis = 1'b0; urs = 1'b0; uif_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_sh",    sh_out, 64'h0);
        chk("rst_buf",   buf_out, 64'h0);
        chk("rst_pend",  pend, 4'h0);
        chk("rst_uif",   uif, 1'b0);
        chk("rst_pulse", upd_pulse, 1'b0);
        chk("rst3_sh",   sh3_out, 48'h5A5A_5A5A_5A5A);

        // direct mode
        pre_en = 4'h0;
        wr(2'd2, 16'h1234);
        chk("dir_sh2",   f4(sh_out, 2), 16'h1234);
        chk("dir_buf2",  f4(buf_out, 2), 16'h1234);
        chk("dir_pend",  pend, 4'h0);
        chk("dir_pulse", upd_pulse, 1'b0);

        // preload mode, uev held 3 cycles gives one update
        pre_en = 4'hF;
        wr(2'd0, 16'h00FF);
        chk("pre_sh0",   f4(sh_out, 0), 16'h0000);
        chk("pre_buf0",  f4(buf_out, 0), 16'h00FF);
        chk("pre_pend",  pend, 4'h1);
        uev = 1'b1;
        tick();
        chk("uev_sh0",   f4(sh_out, 0), 16'h00FF);
        chk("uev_pulse", upd_pulse, 1'b1);
        chk("uev_uif",   uif, 1'b1);
        chk("uev_pend",  pend, 4'h0);
        tick();
        chk("uev_pulse2", upd_pulse, 1'b0);
        tick();
        chk("uev_pulse3", upd_pulse, 1'b0);
        chk("uev_sh2",   f4(sh_out, 2), 16'h1234);
        uev = 1'b0;
        uif_clr = 1'b1;
        tick();
        uif_clr = 1'b0;
        chk("clr_uif",   uif, 1'b0);

        // udis blocks uev rise; dropping udis while uev high gives nothing late
        wr(2'd3, 16'h3333);
        chk("gate_pend0", pend, 4'h8);
        udis = 1'b1; uev = 1'b1;
        tick();
        chk("gate_sh3",   f4(sh_out, 3), 16'h0000);
        chk("gate_pulse", upd_pulse, 1'b0);
        chk("gate_uif",   uif, 1'b0);
        chk("gate_pend",  pend, 4'h8);
        udis = 1'b0;
        tick();
        chk("late_pulse", upd_pulse, 1'b0);
        chk("late_sh3",   f4(sh_out, 3), 16'h0000);
        uev = 1'b0;
        tick();

        // ug ignores udis; urs=1 suppresses uif
        udis = 1'b1; urs = 1'b1; ug = 1'b1;
        tick();
        ug = 1'b0;
        chk("ug_sh3",    f4(sh_out, 3), 16'h3333);
        chk("ug_pulse",  upd_pulse, 1'b1);
        chk("ug_uif",    uif, 1'b0);
        chk("ug_pend",   pend, 4'h0);
        udis = 1'b0; urs = 1'b0; ug = 1'b1;
        tick();
        ug = 1'b0;
        chk("ug_urs0_uif", uif, 1'b1);
        uif_clr = 1'b1;
        tick();
        uif_clr = 1'b0;

        // collision: write on the same edge as uev rise
        wr(2'd1, 16'hAAAA);
        chk("col_pend0", pend, 4'h2);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'hBBBB; uev = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("col_sh1",   f4(sh_out, 1), 16'hAAAA);
        chk("col_buf1",  f4(buf_out, 1), 16'hBBBB);
        chk("col_pend",  pend, 4'h2);
        uev = 1'b0;
        tick();
        uev = 1'b1;
        tick();
        uev = 1'b0;
        chk("col2_sh1",  f4(sh_out, 1), 16'hBBBB);
        chk("col2_pend", pend, 4'h0);

        // set beats simultaneous clear
        uif_clr = 1'b1;
        tick();
        chk("clr2_uif",  uif, 1'b0);
        ug = 1'b1;
        tick();
        ug = 1'b0; uif_clr = 1'b0;
        chk("setwin_uif", uif, 1'b1);

        // pre_en 1->0 with pend set: no transfer, next write direct
        wr(2'd0, 16'h5555);
        chk("sw_pend0",  pend, 4'h1);
        pre_en = 4'hE; ug = 1'b1;
        tick();
        ug = 1'b0;
        chk("sw_sh0",    f4(sh_out, 0), 16'h00FF);
        chk("sw_pend",   pend, 4'h0);
        wr(2'd0, 16'h6666);
        chk("sw_dir_sh0", f4(sh_out, 0), 16'h6666);

        // async reset while a transfer is pending
        pre_en = 4'hF;
        wr(2'd2, 16'h7777);
        chk("mid_pend0", pend, 4'h4);
        #2 rst = 1'b1;
        #1;
        chk("mid_pend",  pend, 4'h0);
        chk("mid_sh",    sh_out, 64'h0);
        chk("mid_buf",   buf_out, 64'h0);
        chk("mid_uif",   uif, 1'b0);
        chk("mid3_buf",  buf3_out, 48'h5A5A_5A5A_5A5A);
        tick();
        rst = 1'b0;
        tick();

        // out-of-range address on the 3-channel instance
        pre_en3 = 3'b000;
        wr(2'd3, 16'hDEAD);
        chk("oor_buf3",  buf3_out, 48'h5A5A_5A5A_5A5A);
        chk("oor_sh3",   sh3_out, 48'h5A5A_5A5A_5A5A);
        chk("oor_pend3", pend3, 3'b000);
        wr(2'd1, 16'h0101);
        chk("in3_sh1",   f3(sh3_out, 1), 16'h0101);
        chk("in3_sh0",   f3(sh3_out, 0), 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
